// File: rtl/inst_d.sv
// Instruction decode stage: IF/ID register, 32x32 register file, hazard detection,
// branch/JR resolution, HALT detection and the ID/EX register. Optional macro: INST_D_WB_BYPASS_EN.
module inst_d #(
    parameter int unsigned NREG      = 32,
    parameter int unsigned IMM_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] pc_in,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [4:0]  mem_rd,
    input  logic        mem_is_load,
    output logic        hazard,
    output logic        redirect,
    output logic [31:0] ex_add,
    output logic        halt,
    output logic        id_valid,
    output logic [5:0]  id_opcode,
    output logic [31:0] id_rs_val,
    output logic [31:0] id_rt_val,
    output logic [4:0]  id_rd,
    output logic [31:0] id_imm,
    output logic [31:0] id_pc
);

    localparam logic [5:0] OP_LDW  = 6'b001100;
    localparam logic [5:0] OP_STW  = 6'b001101;
    localparam logic [5:0] OP_BZ   = 6'b001110;
    localparam logic [5:0] OP_BEQ  = 6'b001111;
    localparam logic [5:0] OP_JR   = 6'b010000;
    localparam logic [5:0] OP_HALT = 6'b010001;

    // IF/ID pipeline register
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;

    logic [31:0] rf [NREG];

    // Decoded IF/ID fields
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [31:0] imm_sext;
    logic        is_rtype, is_itype, is_ldw, is_stw;
    logic        is_bz, is_beq, is_jr, is_halt, is_branch;
    logic        uses_rs, uses_rt;
    logic [4:0]  dest;
    logic [31:0] rs_val, rt_val;
    logic [31:0] br_target;
    logic        issue, halting;

    function automatic logic src_hit(input logic [4:0] r,
                                     input logic [4:0] a_rs, input logic [4:0] a_rt,
                                     input logic u_rs, input logic u_rt);
        return (r != '0) && ((u_rs && (a_rs == r)) || (u_rt && (a_rt == r)));
    endfunction

    always_comb begin
        op        = ifid_instr[31:26];
        rs        = ifid_instr[25:21];
        rt        = ifid_instr[20:16];
        rd        = ifid_instr[15:11];
        imm16     = ifid_instr[15:0];
        imm_sext  = {{16{imm16[15]}}, imm16};
        is_rtype  = (op <= 6'd10) && !op[0];
        is_itype  = (op <= 6'd11) &&  op[0];
        is_ldw    = (op == OP_LDW);
        is_stw    = (op == OP_STW);
        is_bz     = (op == OP_BZ);
        is_beq    = (op == OP_BEQ);
        is_jr     = (op == OP_JR);
        is_halt   = (op == OP_HALT);
        is_branch = is_bz || is_beq || is_jr;
        uses_rs   = !is_halt;
        uses_rt   = is_rtype || is_stw || is_beq;
        dest      = '0;
        if (is_rtype) begin
            dest = rd;
        end else if (is_itype || is_ldw) begin
            dest = rt;
        end
    end

    // Register-file read ports; R0 is never written so it always reads zero
    always_comb begin
        rs_val = rf[rs];
        rt_val = rf[rt];
`ifdef INST_D_WB_BYPASS_EN
        if (wb_en && (wb_addr != '0) && (wb_addr == rs)) rs_val = wb_data;
        if (wb_en && (wb_addr != '0) && (wb_addr == rt)) rt_val = wb_data;
`endif
    end

    // Branches read operands in ID, so any in-flight producer stalls them
    always_comb begin
        hazard = 1'b0;
        if (id_valid && (id_opcode == OP_LDW) && src_hit(id_rd, rs, rt, uses_rs, uses_rt))
            hazard = 1'b1;
        if (is_branch && id_valid && src_hit(id_rd, rs, rt, uses_rs, uses_rt))
            hazard = 1'b1;
        if (is_branch && mem_is_load && src_hit(mem_rd, rs, rt, uses_rs, uses_rt))
            hazard = 1'b1;
`ifndef INST_D_WB_BYPASS_EN
        if (wb_en && src_hit(wb_addr, rs, rt, uses_rs, uses_rt))
            hazard = 1'b1;
`endif
        hazard = hazard && ifid_valid;
    end

    always_comb begin
        issue     = ifid_valid && !hazard;
        halting   = issue && is_halt;
        br_target = ifid_pc + (imm_sext << IMM_SHIFT);
        redirect  = issue && (is_jr || (is_bz && (rs_val == '0)) || (is_beq && (rs_val == rt_val)));
        ex_add    = '0;
        if (redirect) begin
            ex_add = is_jr ? rs_val : br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_en && (wb_addr != '0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Redirect flushes the sequential slot; HALT blocks every later fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
        end else if (!hazard) begin
            if (redirect || halt || halting) begin
                ifid_valid <= 1'b0;
                ifid_instr <= '0;
                ifid_pc    <= '0;
            end else begin
                ifid_valid <= 1'b1;
                ifid_instr <= instruction;
                ifid_pc    <= pc_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt <= 1'b0;
        end else if (halting) begin
            halt <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !issue) begin
            id_valid  <= 1'b0;
            id_opcode <= '0;
            id_rs_val <= '0;
            id_rt_val <= '0;
            id_rd     <= '0;
            id_imm    <= '0;
            id_pc     <= '0;
        end else begin
            id_valid  <= 1'b1;
            id_opcode <= op;
            id_rs_val <= rs_val;
            id_rt_val <= rt_val;
            id_rd     <= dest;
            id_imm    <= imm_sext;
            id_pc     <= ifid_pc;
        end
    end

endmodule

// File: tb/tb_inst_d.sv
// Scoreboard bench for inst_d: directed instruction stream, expected ID/EX records queued
// at fetch time and popped by a monitor whenever id_valid is presented.
module tb_inst_d;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction, pc_in;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  mem_rd;
    logic        mem_is_load;
    logic        hazard, redirect, halt, id_valid;
    logic [31:0] ex_add, id_rs_val, id_rt_val, id_imm, id_pc;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rd;

    always #5 clk = ~clk;

    inst_d #(.NREG(32), .IMM_SHIFT(2)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc_in(pc_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_rd(mem_rd), .mem_is_load(mem_is_load),
        .hazard(hazard), .redirect(redirect), .ex_add(ex_add), .halt(halt),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_rs_val(id_rs_val),
        .id_rt_val(id_rt_val), .id_rd(id_rd), .id_imm(id_imm), .id_pc(id_pc)
    );

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
    } rec_t;

    rec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic [31:0] rsv, input logic [31:0] rtv,
                        input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc);
        rec_t r;
        r = '{op: op, rsv: rsv, rtv: rtv, rd: rd, imm: imm, pc: pc};
        sb.push_back(r);
    endtask

    task automatic feed(input logic [31:0] ins, input logic [31:0] pc);
        instruction = ins;
        pc_in       = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic [31:0] pc);
        push(6'd0, 32'd0, 32'd0, 5'd0, 32'd0, pc);
        feed(32'd0, pc);
    endtask

    task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    always @(negedge clk) begin
        rec_t got, exp;
        if (id_valid === 1'b1) begin
            got = '{op: id_opcode, rsv: id_rs_val, rtv: id_rt_val, rd: id_rd, imm: id_imm, pc: id_pc};
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_issue: got %h expected no issue", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL issue_record: got %h expected %h", got, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_LDW  = 6'd12;
    localparam logic [5:0] OP_BZ   = 6'd14;
    localparam logic [5:0] OP_BEQ  = 6'd15;
    localparam logic [5:0] OP_JR   = 6'd16;
    localparam logic [5:0] OP_HALT = 6'd17;

    logic [31:0] add_a, add_c, fill, ldw1, ldw5, ldw3, beq1, bz0, bz7, bz1, addi5, jr5, halt_i;

    initial begin
        add_a  = enc_r(OP_ADD, 5'd3, 5'd1, 5'd4);
        add_c  = enc_r(OP_ADD, 5'd7, 5'd0, 5'd6);
        fill   = enc_r(OP_ADD, 5'd0, 5'd0, 5'd9);
        ldw1   = enc_i(OP_LDW, 5'd1, 5'd3, 16'h0000);
        ldw5   = enc_i(OP_LDW, 5'd0, 5'd5, 16'h0010);
        ldw3   = enc_i(OP_LDW, 5'd0, 5'd3, 16'h0000);
        beq1   = enc_i(OP_BEQ, 5'd1, 5'd2, 16'h0003);
        bz0    = enc_i(OP_BZ, 5'd6, 5'd0, 16'hFFFE);
        bz7    = enc_i(OP_BZ, 5'd7, 5'd0, 16'hFFFE);
        bz1    = enc_i(OP_BZ, 5'd1, 5'd0, 16'h0002);
        addi5  = enc_i(OP_ADDI, 5'd1, 5'd5, 16'h0100);
        jr5    = enc_i(OP_JR, 5'd5, 5'd0, 16'h0000);
        halt_i = {OP_HALT, 26'd0};

        rst = 1'b1; instruction = add_a; pc_in = '0;
        set_wb(1'b0, 5'd0, 32'd0); mem_rd = '0; mem_is_load = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_ctrl", {28'd0, hazard, redirect, halt, id_valid}, 32'd0);
            chk("rst_ex_add", ex_add, 32'd0);
            chk("rst_id_fields", {21'd0, id_rd, id_opcode} | id_rs_val | id_rt_val | id_imm | id_pc, 32'd0);
        end
        rst = 1'b0;

        push(OP_ADD, 32'd0, 32'd0, 5'd4, 32'h2000, 32'h0);
        feed(add_a, 32'h0);
        chk("first_latency", id_valid, 32'd0);
        nop(32'h4);
        chk("first_issue", id_valid, 32'd1);

        set_wb(1'b1, 5'd1, 32'd5);    nop(32'h8);
        set_wb(1'b1, 5'd2, 32'd5);    nop(32'hC);
        set_wb(1'b1, 5'd3, 32'h30);   nop(32'h10);
        set_wb(1'b0, 5'd0, 32'd0);

        // load-use
        push(OP_LDW, 32'd5, 32'h30, 5'd3, 32'd0, 32'h14);
        feed(ldw1, 32'h14);
        chk("ldw_no_hazard", hazard, 32'd0);
        push(OP_ADD, 32'h30, 32'd5, 5'd4, 32'h2000, 32'h18);
        feed(add_a, 32'h18);
        chk("load_use_hazard", hazard, 32'd1);
        feed(add_a, 32'h18);
        chk("load_use_bubble", id_valid, 32'd0);
        chk("load_use_clear", hazard, 32'd0);
        nop(32'h1C);
        chk("load_use_issue", id_valid, 32'd1);

        // BEQ taken
        push(OP_BEQ, 32'd5, 32'd5, 5'd0, 32'd3, 32'h40);
        feed(beq1, 32'h40);
        chk("beq_hazard", hazard, 32'd0);
        chk("beq_redirect", redirect, 32'd1);
        chk("beq_target", ex_add, 32'h4C);
        feed(fill, 32'h44);
        chk("beq_redirect_drop", redirect, 32'd0);
        chk("beq_ex_add_zero", ex_add, 32'd0);
        nop(32'h4C);
        chk("beq_flushed", id_valid, 32'd0);

        // BZ taken, negative offset
        push(OP_BZ, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFE, 32'h8);
        feed(bz0, 32'h8);
        chk("bz_taken", redirect, 32'd1);
        chk("bz_target", ex_add, 32'h0);
        feed(fill, 32'hC);
        nop(32'h0);

        // BZ not taken
        set_wb(1'b1, 5'd7, 32'd7); nop(32'h4); set_wb(1'b0, 5'd0, 32'd0);
        push(OP_BZ, 32'd7, 32'd0, 5'd0, 32'hFFFF_FFFE, 32'h8);
        feed(bz7, 32'h8);
        chk("bz_not_taken", redirect, 32'd0);
        chk("bz_nt_ex_add", ex_add, 32'd0);
        chk("bz_nt_hazard", hazard, 32'd0);
        nop(32'hC);

        // ADDI R5 then JR R5
        push(OP_ADDI, 32'd5, 32'd0, 5'd5, 32'h100, 32'h20);
        feed(addi5, 32'h20);
        push(OP_JR, 32'h105, 32'd0, 5'd0, 32'd0, 32'h24);
        feed(jr5, 32'h24);
        chk("jr_raw_hazard", hazard, 32'd1);
        chk("jr_stall_no_redirect", redirect, 32'd0);
        set_wb(1'b1, 5'd5, 32'h105);
        feed(jr5, 32'h24);
        set_wb(1'b0, 5'd0, 32'd0); #1;
        chk("jr_bubble", id_valid, 32'd0);
        chk("jr_hazard_clear", hazard, 32'd0);
        chk("jr_redirect", redirect, 32'd1);
        chk("jr_target", ex_add, 32'h105);
        feed(fill, 32'h28);
        nop(32'h105);

        // LDW R5, NOP, JR R5: load sits in MEM
        push(OP_LDW, 32'd0, 32'h105, 5'd5, 32'h10, 32'h30);
        feed(ldw5, 32'h30);
        nop(32'h34);
        push(OP_JR, 32'hABC, 32'd0, 5'd0, 32'd0, 32'h38);
        feed(jr5, 32'h38);
        mem_rd = 5'd5; mem_is_load = 1'b1; #1;
        chk("mem_load_hazard", hazard, 32'd1);
        chk("mem_load_no_redirect", redirect, 32'd0);
        feed(jr5, 32'h38);
        mem_rd = 5'd0; mem_is_load = 1'b0; set_wb(1'b1, 5'd5, 32'hABC); #1;
`ifdef INST_D_WB_BYPASS_EN
        chk("wb_bypass_no_hazard", hazard, 32'd0);
        chk("wb_bypass_redirect", redirect, 32'd1);
        chk("wb_bypass_target", ex_add, 32'hABC);
        feed(fill, 32'h3C);
        set_wb(1'b0, 5'd0, 32'd0);
`else
        chk("wb_raw_hazard", hazard, 32'd1);
        feed(jr5, 32'h38);
        set_wb(1'b0, 5'd0, 32'd0); #1;
        chk("jr_load_hazard_clear", hazard, 32'd0);
        chk("jr_load_redirect", redirect, 32'd1);
        chk("jr_load_target", ex_add, 32'hABC);
        feed(fill, 32'h3C);
`endif
        nop(32'hABC);

        // write-back and read of the same register in one cycle
        push(OP_ADD, 32'h77, 32'd0, 5'd6, 32'h3000, 32'h50);
        feed(add_c, 32'h50);
        set_wb(1'b1, 5'd7, 32'h77); #1;
`ifdef INST_D_WB_BYPASS_EN
        chk("wb_same_cycle_hazard", hazard, 32'd0);
        nop(32'h54);
        set_wb(1'b0, 5'd0, 32'd0);
`else
        chk("wb_same_cycle_hazard", hazard, 32'd1);
        feed(add_c, 32'h50);
        set_wb(1'b0, 5'd0, 32'd0); #1;
        chk("wb_same_cycle_clear", hazard, 32'd0);
        nop(32'h54);
`endif

        // HALT
        push(OP_HALT, 32'd0, 32'd0, 5'd0, 32'd0, 32'h60);
        feed(halt_i, 32'h60);
        chk("halt_not_yet", halt, 32'd0);
        feed(add_a, 32'h64);
        chk("halt_set", halt, 32'd1);
        for (int i = 0; i < 3; i++) begin
            feed(add_a, 32'h68 + 32'(4 * i));
            chk("halt_no_issue", id_valid, 32'd0);
            chk("halt_sticky", halt, 32'd1);
        end

        rst = 1'b1;
        feed(add_a, 32'h74);
        rst = 1'b0; #1;
        chk("rst_halt_clear", halt, 32'd0);
        chk("rst_pipe_empty", {30'd0, id_valid, hazard}, 32'd0);

        // reset during a stall
        push(OP_LDW, 32'd0, 32'd0, 5'd3, 32'd0, 32'h80);
        feed(ldw3, 32'h80);
        feed(add_a, 32'h84);
        chk("stall_before_rst", hazard, 32'd1);
        rst = 1'b1;
        feed(add_a, 32'h84);
        rst = 1'b0; #1;
        chk("rst_mid_stall_valid", id_valid, 32'd0);
        chk("rst_mid_stall_hazard", hazard, 32'd0);

        // register file cleared: BZ on R1 now taken
        push(OP_BZ, 32'd0, 32'd0, 5'd0, 32'd2, 32'h90);
        feed(bz1, 32'h90);
        chk("rf_cleared_redirect", redirect, 32'd1);
        chk("rf_cleared_target", ex_add, 32'h98);
        feed(fill, 32'h94);
        nop(32'h98);
        nop(32'h9C);
        feed(32'd0, 32'hA0);
        @(negedge clk); #1;
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_d.md
# inst_d

Instruction decode stage for the MIPS-lite pipeline, sitting directly behind the instruction fetch stage and consuming its `instruction`/`pc_out` stream. Holds the IF/ID pipeline register, the 32x32 register file and the ID/EX output register. Returns `hazard` (stall) and `ex_add`/`redirect` (branch/jump target) to fetch. Branches (BZ, BEQ, JR) resolve here, and HALT is detected here.

## Interface
Parameters:
- `NREG`, 32: register-file depth; R0 is hardwired to zero.
- `IMM_SHIFT`, 2: left shift applied to the branch immediate (word to byte offset).

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instruction` in 32: fetched instruction from fetch.
- `pc_in` in 32: PC of `instruction`.
- `wb_en` in 1: write-back enable.
- `wb_addr` in 5: write-back register index.
- `wb_data` in 32: write-back data.
- `mem_rd` in 5: destination register of the instruction in MEM.
- `mem_is_load` in 1: instruction in MEM is LDW.
- `hazard` out 1: stall fetch; combinational.
- `redirect` out 1: taken branch/JR in ID; combinational.
- `ex_add` out 32: redirect target; valid when `redirect`=1.
- `halt` out 1: sticky, set once HALT leaves ID.
- `id_valid` out 1: ID/EX holds a real instruction.
- `id_opcode` out 6; `id_rs_val` out 32; `id_rt_val` out 32; `id_rd` out 5; `id_imm` out 32 (sign-extended); `id_pc` out 32: ID/EX register fields.

## Operation
- Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
- Destination:
  - R-type ALU (even opcodes 000000–001010): `rd`.
  - I-type ALU and LDW: `rt`.
  - STW, BZ, BEQ, JR, HALT: none, so `id_rd`=0.
- Sources:
  - rs for all except HALT.
  - rt also for R-type, STW and BEQ.
- IF/ID register:
  - Loads `instruction`/`pc_in` with valid=1 when `hazard`=0 and `halt`=0.
  - Holds its contents when `hazard`=1.
  - Loads valid=0 on the edge after `redirect`=1 (flushes the sequentially fetched slot).
- Register file:
  - Two combinational read ports, one write port.
  - Writes to R0 are ignored.
- Branch resolution, only when IF/ID is valid and `hazard`=0:
  - BZ (001110): taken if R[rs]==0.
  - BEQ (001111): taken if R[rs]==R[rt].
  - JR (010000): always taken.
  - BZ/BEQ target: `pc_if_id + (sext(imm) << IMM_SHIFT)`, computed mod 2^32.
  - JR target: R[rs].
  - When taken, `redirect`=1 and `ex_add`=target; otherwise `ex_add`=0.
- Hazard, asserted when IF/ID is valid and a nonzero source register matches any of:
  - the ID/EX destination while ID/EX is a valid LDW (load-use);
  - the ID/EX destination while the IF/ID instruction is a branch/JR (no forwarding into ID);
  - `mem_rd` with `mem_is_load`=1 while the IF/ID instruction is a branch/JR.
- When `hazard`=1: the ID/EX register takes a bubble (`id_valid`=0, all fields 0), and IF/ID holds.
- HALT (010001):
  - Passes to ID/EX with `id_valid`=1 so downstream stages drain.
  - `halt` is set on the same edge.
  - After that, IF/ID captures valid=0 every cycle until `rst`.
- Branches and JR pass into ID/EX with `id_valid`=1 so that execution counts are correct.

## Timing
- Reset: all outputs 0, IF/ID valid=0, ID/EX valid=0, register file cleared, `halt`=0.
- Reset takes priority over every other event, including mid-stall and mid-redirect.
- IF/ID to ID/EX latency: 1 cycle.
- `hazard`, `redirect` and `ex_add` are combinational from IF/ID, ID/EX and register-file state, with no added latency.
- A redirect costs 1 flushed slot; fetch loads `ex_add` on the same edge.
- `hazard` and `redirect` are never both 1; a stalled branch does not resolve.
- Write-back to register X and a read of X in the same cycle: see Configuration.

## Configuration
- `INST_D_WB_BYPASS_EN` defined:
  - Register-file reads return `wb_data` when `wb_en`=1 and `wb_addr` equals the source register (nonzero).
- `INST_D_WB_BYPASS_EN` undefined:
  - Reads return the stored value.
  - `hazard` additionally asserts when `wb_en`=1 and `wb_addr` matches a nonzero source register of the IF/ID instruction.

## Test plan
- Reset held for 3 cycles while `instruction`=ADD -> all outputs 0. After release, the first ADD appears with `id_valid`=1 one cycle later.
- LDW R3 followed by ADD R4=R3+R1 -> `hazard`=1 for exactly 1 cycle, one bubble (`id_valid`=0), then the ADD issues.
- BEQ R1,R2,imm=+3 at PC 0x40 with R1=R2=5 -> `redirect`=1, `ex_add`=0x4C. The next IF/ID is flushed (`id_valid`=0 two cycles later).
- BZ with imm=-2 at PC 0x08 and R[rs]=0 -> `ex_add`=0x00. With R[rs]=7 -> `redirect`=0.
- ADDI R5 followed immediately by JR R5 -> 1-cycle stall, then `ex_add`=R5's new value. LDW R5 followed by NOP then JR R5 -> stall while the load is in MEM.
- HALT -> `halt`=1 after 1 cycle, with no further `id_valid`=1. Assert `rst` mid-stream -> `halt`=0 and the pipeline is empty on the next edge.
